pi_request_queue: RTL and testbench



---
 rtl/pi_request_queue_pkg.sv | 36 +++
 rtl/pi_request_queue_if.sv | 25 ++
 rtl/pi_request_queue_req_fifo.sv | 69 ++++++
 rtl/pi_request_queue.sv | 184 ++++++++++++++++++
 tb/tb_pi_request_queue.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pi_request_queue_pkg.sv
// Shared definitions for the Pi request queue: register map, descriptor layout, version.
package pi_request_queue_pkg;

  // Register addresses on PI_A
  localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
  localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
  localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
  localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;
  localparam logic [2:0] PI_REG_STATUS  = 3'd4;  // read side
  localparam logic [2:0] PI_REG_CONTROL = 3'd4;  // write side
  localparam logic [2:0] PI_REG_VERSION = 3'd7;

  localparam logic [15:0] FW_VERSION = 16'h0103;

  // Field offsets inside an ADDR_HI write word
  localparam int unsigned AH_ADDR_LSB = 0;   // address[23:16], 8 bits
  localparam int unsigned AH_SIZE_LSB = 8;   // size, 2 bits
  localparam int unsigned AH_READ_BIT = 10;  // read flag
  localparam int unsigned AH_FC_LSB   = 11;  // function code, 3 bits

  localparam int unsigned DESC_W = 62;

  typedef struct packed {
    logic [2:0]  fc;
    logic        read;
    logic [1:0]  size;
    logic [23:0] address;
    logic [31:0] data;
  } req_desc_t;

  // Readback word for ADDR_HI: the inverse of the ADDR_HI write layout
  function automatic logic [15:0] addr_hi_word(input req_desc_t d);
    return {2'b00, d.fc, d.read, d.size, d.address[23:16]};
  endfunction

endpackage

// File: rtl/pi_request_queue_if.sv
// Request/response handshake between the Pi request queue and the Amiga bus FSM.
interface pi_request_queue_if;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [23:0] REQ_ADDRESS;
  logic [31:0] REQ_DATA;
  logic [1:0]  REQ_SIZE;
  logic        REQ_READ;
  logic [2:0]  REQ_FC;
  logic        RSP_VALID;
  logic [31:0] RSP_DATA;
  logic        RSP_TERM_OK;

  // Queue side: issues requests, receives completions
  modport master (
    output REQ_VALID, REQ_ADDRESS, REQ_DATA, REQ_SIZE, REQ_READ, REQ_FC,
    input  REQ_READY, RSP_VALID, RSP_DATA, RSP_TERM_OK
  );

  // Bus FSM side
  modport slave (
    input  REQ_VALID, REQ_ADDRESS, REQ_DATA, REQ_SIZE, REQ_READ, REQ_FC,
    output REQ_READY, RSP_VALID, RSP_DATA, RSP_TERM_OK
  );
endinterface

// File: rtl/pi_request_queue_req_fifo.sv
// Synchronous descriptor FIFO with a registered head entry (no write-to-head bypass).
module pi_request_queue_req_fifo
  import pi_request_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  req_desc_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output logic      head_valid_o,
  output req_desc_t head_o
);

  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = PtrW + 1;

  req_desc_t           mem_q [DEPTH];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0]   count_q;
  logic                head_valid_q;
  req_desc_t           head_q;
  logic                do_push, do_pop;

  assign full_o  = (count_q == CountW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A push into a full FIFO is only accepted when the head leaves in the same cycle
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CountW'(do_push) - CountW'(do_pop);
    end
  end

  // Head register trails storage by one cycle; an empty FIFO shows a zero head
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head_valid_q <= 1'b0;
      head_q       <= '0;
    end else begin
      head_valid_q <= ~empty_o;
      head_q       <= empty_o ? '0 : mem_q[rd_ptr_q];
    end
  end

  assign head_valid_o = head_valid_q;
  assign head_o       = head_q;

endmodule

// File: rtl/pi_request_queue.sv
// Pi GPIO front end: strobe synchroniser, register decode, request FIFO, in-flight tracking.
module pi_request_queue
  import pi_request_queue_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                SYSCLK,
  input  logic                RESET,
  input  logic                PI_WR,
  input  logic [2:0]          PI_A,
  input  logic [15:0]         PI_DATA_IN,
  output logic [15:0]         PI_DATA_OUT,
  output logic                PI_BUSY,
  output logic [14:0]         CONTROL,
  pi_request_queue_if.master  bus_io
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   wr_event;
  logic                   wr_evt_q;
  logic [2:0]             wr_addr_q;
  logic [15:0]            wr_data_q;

  logic [31:0] stg_data_q, stg_data_d;
  logic [15:0] stg_addr_q, stg_addr_d;
  logic [14:0] control_q, control_d;
  logic        overflow_q, overflow_d;
  logic        in_flight_q, in_flight_d;
  logic        term_ok_q, term_ok_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        push, ctrl_clr_ovf;
  req_desc_t   push_desc, head;
  logic        fifo_full, fifo_empty, head_valid;
  logic        req_valid, req_fire, rsp_take, busy;

  // Synchroniser and history flop; reset to 0 so a strobe held low through reset is not a write
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], PI_WR};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign wr_event = hist_q & ~sync_q[SYNC_STAGES-1];

  // Capture address and data at the write event; decode acts on the next cycle
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      wr_evt_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_evt_q <= wr_event;
      if (wr_event) begin
        wr_addr_q <= PI_A;
        wr_data_q <= PI_DATA_IN;
      end
    end
  end

  // Register write decode: staging, push request, control set/clear
  always_comb begin
    stg_data_d   = stg_data_q;
    stg_addr_d   = stg_addr_q;
    control_d    = control_q;
    ctrl_clr_ovf = 1'b0;
    push         = 1'b0;
    if (wr_evt_q) begin
      case (wr_addr_q)
        PI_REG_DATA_LO: stg_data_d[15:0]  = wr_data_q;
        PI_REG_DATA_HI: stg_data_d[31:16] = wr_data_q;
        PI_REG_ADDR_LO: stg_addr_d        = wr_data_q;
        PI_REG_ADDR_HI: push              = 1'b1;
        PI_REG_CONTROL: begin
          if (wr_data_q[15]) begin
            control_d = control_q | wr_data_q[14:0];
          end else begin
            control_d    = control_q & ~wr_data_q[14:0];
            ctrl_clr_ovf = wr_data_q[14];
          end
        end
        default: ;
      endcase
    end
  end

  // Descriptor assembled from staging registers plus the ADDR_HI word
  always_comb begin
    push_desc         = '0;
    push_desc.address = {wr_data_q[AH_ADDR_LSB +: 8], stg_addr_q};
    push_desc.data    = stg_data_q;
    push_desc.size    = wr_data_q[AH_SIZE_LSB +: 2];
    push_desc.read    = wr_data_q[AH_READ_BIT];
    push_desc.fc      = wr_data_q[AH_FC_LSB +: 3];
  end

  pi_request_queue_req_fifo #(
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk_i        (SYSCLK),
    .rst_i        (RESET),
    .push_i       (push),
    .push_data_i  (push_desc),
    .pop_i        (req_fire),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .head_valid_o (head_valid),
    .head_o       (head)
  );

  // Only one request outstanding: the head is hidden while a bus cycle is in flight
  assign req_valid = head_valid & ~in_flight_q;
  assign req_fire  = req_valid & bus_io.REQ_READY;
  assign rsp_take  = bus_io.RSP_VALID & in_flight_q;
  assign busy      = ~fifo_empty | in_flight_q;

  // Next state for in-flight tracking, response capture and sticky overflow
  always_comb begin
    in_flight_d = in_flight_q;
    term_ok_d   = term_ok_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q;
    if (req_fire) begin
      in_flight_d = 1'b1;
    end else if (rsp_take) begin
      in_flight_d = 1'b0;
      term_ok_d   = bus_io.RSP_TERM_OK;
      rd_data_d   = bus_io.RSP_DATA;
    end
    if (push && fifo_full && !req_fire) overflow_d = 1'b1;
    if (ctrl_clr_ovf) overflow_d = 1'b0;
  end

  // Architectural state
  always_ff @(posedge SYSCLK) begin
    if (RESET) begin
      stg_data_q  <= '0;
      stg_addr_q  <= '0;
      control_q   <= '0;
      overflow_q  <= 1'b0;
      in_flight_q <= 1'b0;
      term_ok_q   <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      stg_data_q  <= stg_data_d;
      stg_addr_q  <= stg_addr_d;
      control_q   <= control_d;
      overflow_q  <= overflow_d;
      in_flight_q <= in_flight_d;
      term_ok_q   <= term_ok_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Pi read mux
  always_comb begin
    PI_DATA_OUT = '0;
    case (PI_A)
      PI_REG_DATA_LO: PI_DATA_OUT = rd_data_q[15:0];
      PI_REG_DATA_HI: PI_DATA_OUT = rd_data_q[31:16];
      PI_REG_ADDR_LO: PI_DATA_OUT = head.address[15:0];
      PI_REG_ADDR_HI: PI_DATA_OUT = addr_hi_word(head);
      PI_REG_STATUS:  PI_DATA_OUT = {11'b0, overflow_q, fifo_full, busy, term_ok_q, in_flight_q};
      PI_REG_VERSION: PI_DATA_OUT = FW_VERSION;
      default: ;
    endcase
  end

  assign PI_BUSY            = busy;
  assign CONTROL            = control_q;
  assign bus_io.REQ_VALID   = req_valid;
  assign bus_io.REQ_ADDRESS = head.address;
  assign bus_io.REQ_DATA    = head.data;
  assign bus_io.REQ_SIZE    = head.size;
  assign bus_io.REQ_READ    = head.read;
  assign bus_io.REQ_FC      = head.fc;

endmodule

// File: tb/tb_pi_request_queue.sv
// Self-checking bench for pi_request_queue: directed tables, corner sequences, random vs model.
module tb_pi_request_queue;

  localparam int unsigned DEPTH       = 4;
  localparam int unsigned SYNC_STAGES = 2;
  localparam logic [15:0] VERSION     = 16'h0103;

  logic        SYSCLK = 1'b0;
  logic        RESET;
  logic        PI_WR;
  logic [2:0]  PI_A;
  logic [15:0] PI_DATA_IN;
  logic [15:0] PI_DATA_OUT;
  logic        PI_BUSY;
  logic [14:0] CONTROL;

  pi_request_queue_if bus_if ();

  pi_request_queue #(
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .SYSCLK      (SYSCLK),
    .RESET       (RESET),
    .PI_WR       (PI_WR),
    .PI_A        (PI_A),
    .PI_DATA_IN  (PI_DATA_IN),
    .PI_DATA_OUT (PI_DATA_OUT),
    .PI_BUSY     (PI_BUSY),
    .CONTROL     (CONTROL),
    .bus_io      (bus_if)
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    logic        rd;
    logic [2:0]  fc;
  } m_desc_t;

  typedef struct {
    logic [15:0] in;
    logic [15:0] exp;
  } vec_t;

  // Reference model state
  m_desc_t     mq[$];
  bit          m_inflight;
  logic [31:0] m_rd;
  bit          m_term;
  bit          m_ovf;
  logic [14:0] m_ctrl;
  logic [31:0] m_stg;
  logic [15:0] m_stga;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    mq.delete();
    m_inflight = 0;
    m_rd = '0;
    m_term = 0;
    m_ovf = 0;
    m_ctrl = '0;
    m_stg = '0;
    m_stga = '0;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [15:0] d);
    m_desc_t x;
    case (a)
      3'd0: m_stg[15:0] = d;
      3'd1: m_stg[31:16] = d;
      3'd2: m_stga = d;
      3'd3: begin
        x.addr = {d[7:0], m_stga};
        x.data = m_stg;
        x.size = d[9:8];
        x.rd   = d[10];
        x.fc   = d[13:11];
        if (mq.size() < DEPTH) mq.push_back(x);
        else m_ovf = 1;
      end
      3'd4: begin
        if (d[15]) m_ctrl = m_ctrl | d[14:0];
        else begin
          m_ctrl = m_ctrl & ~d[14:0];
          if (d[14]) m_ovf = 0;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic pi_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge SYSCLK);
    PI_A = a;
    PI_DATA_IN = d;
    PI_WR = 1'b0;
    repeat (6) @(negedge SYSCLK);
    PI_WR = 1'b1;
    repeat (4) @(negedge SYSCLK);
    model_write(a, d);
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] v);
    PI_A = a;
    #1;
    v = PI_DATA_OUT;
  endtask

  task automatic handshake();
    bit ev;
    ev = (mq.size() != 0) && !m_inflight;
    @(negedge SYSCLK);
    bus_if.REQ_READY = 1'b1;
    @(negedge SYSCLK);
    bus_if.REQ_READY = 1'b0;
    @(negedge SYSCLK);
    if (ev) begin
      mq.delete(0);
      m_inflight = 1;
    end
  endtask

  task automatic respond(input logic [31:0] d, input logic ok);
    @(negedge SYSCLK);
    bus_if.RSP_VALID = 1'b1;
    bus_if.RSP_DATA = d;
    bus_if.RSP_TERM_OK = ok;
    @(negedge SYSCLK);
    bus_if.RSP_VALID = 1'b0;
    if (m_inflight) begin
      m_rd = d;
      m_term = ok;
      m_inflight = 0;
    end
  endtask

  task automatic check_head(input string tag, input m_desc_t e);
    check({tag, " req_address"}, bus_if.REQ_ADDRESS, e.addr);
    check({tag, " req_data"}, bus_if.REQ_DATA, e.data);
    check({tag, " req_fc/read/size"}, {bus_if.REQ_FC, bus_if.REQ_READ, bus_if.REQ_SIZE},
          {e.fc, e.rd, e.size});
  endtask

  task automatic check_model(input string tag);
    logic [15:0] v;
    bit busy, ev, full;
    busy = (mq.size() != 0) || m_inflight;
    ev   = (mq.size() != 0) && !m_inflight;
    full = (mq.size() == DEPTH);
    check({tag, " busy"}, PI_BUSY, busy);
    check({tag, " control"}, CONTROL, m_ctrl);
    check({tag, " req_valid"}, bus_if.REQ_VALID, ev);
    if (ev) check_head(tag, mq[0]);
    read_reg(3'd4, v);
    check({tag, " status"}, v, {11'b0, m_ovf, full, busy, m_term, m_inflight});
    read_reg(3'd0, v);
    check({tag, " data_lo"}, v, m_rd[15:0]);
    read_reg(3'd1, v);
    check({tag, " data_hi"}, v, m_rd[31:16]);
    read_reg(3'd2, v);
    check({tag, " addr_lo"}, v, (mq.size() != 0) ? mq[0].addr[15:0] : 16'h0);
    read_reg(3'd3, v);
    check({tag, " addr_hi"}, v, (mq.size() != 0) ?
          {2'b00, mq[0].fc, mq[0].rd, mq[0].size, mq[0].addr[23:16]} : 16'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        rd_tab[8];
    vec_t        ctl_tab[6];
    logic [15:0] v, w;

    rd_tab = '{'{16'd0, 16'hBEEF}, '{16'd1, 16'hDEAD}, '{16'd2, 16'h0000}, '{16'd3, 16'h0000},
               '{16'd4, 16'h0002}, '{16'd5, 16'h0000}, '{16'd6, 16'h0000}, '{16'd7, VERSION}};
    ctl_tab = '{'{16'h8003, 16'h0003}, '{16'h0001, 16'h0002}, '{16'h8070, 16'h0072},
                '{16'h0030, 16'h0042}, '{16'hC100, 16'h4142}, '{16'h7FFF, 16'h0000}};

    RESET = 1'b1;
    PI_WR = 1'b1;
    PI_A = '0;
    PI_DATA_IN = '0;
    bus_if.REQ_READY = 1'b0;
    bus_if.RSP_VALID = 1'b0;
    bus_if.RSP_DATA = '0;
    bus_if.RSP_TERM_OK = 1'b0;
    model_reset();
    repeat (3) @(negedge SYSCLK);
    RESET = 1'b0;
    repeat (4) @(negedge SYSCLK);

    // Reset state
    check("reset req_valid", bus_if.REQ_VALID, 0);
    check("reset req_address", bus_if.REQ_ADDRESS, 0);
    check("reset req_data", bus_if.REQ_DATA, 0);
    read_reg(3'd7, v);
    check("reset version", v, VERSION);
    check_model("reset");

    // Single write request with push latency
    pi_write(3'd0, 16'h1234);
    pi_write(3'd1, 16'hABCD);
    pi_write(3'd2, 16'h0010);
    @(negedge SYSCLK);
    PI_A = 3'd3;
    PI_DATA_IN = 16'h08FC;
    PI_WR = 1'b0;
    repeat (3) @(negedge SYSCLK);
    check("push busy before push", PI_BUSY, 0);
    @(negedge SYSCLK);
    check("push busy at push", PI_BUSY, 1);
    check("push req_valid not yet", bus_if.REQ_VALID, 0);
    @(negedge SYSCLK);
    check("push req_valid 4 cycles", bus_if.REQ_VALID, 1);
    @(negedge SYSCLK);
    PI_WR = 1'b1;
    repeat (4) @(negedge SYSCLK);
    model_write(3'd3, 16'h08FC);
    check("single req_address", bus_if.REQ_ADDRESS, 24'hFC0010);
    check("single req_data", bus_if.REQ_DATA, 32'hABCD1234);
    check("single req_fc", bus_if.REQ_FC, 3'd1);
    check_model("single");

    // Read completion
    handshake();
    check("handshake req_valid low", bus_if.REQ_VALID, 0);
    read_reg(3'd4, v);
    check("handshake status", v, 16'h0005);
    respond(32'hDEADBEEF, 1'b1);
    check("completion busy low", PI_BUSY, 0);
    for (int i = 0; i < 8; i++) begin
      read_reg(rd_tab[i].in[2:0], v);
      check($sformatf("readmux a=%0d", rd_tab[i].in), v, rd_tab[i].exp);
    end

    // Control set/clear table
    for (int i = 0; i < 6; i++) begin
      pi_write(3'd4, ctl_tab[i].in);
      check($sformatf("control wr=0x%04h", ctl_tab[i].in), CONTROL, ctl_tab[i].exp[14:0]);
    end

    // Overflow: five pushes into a four-entry queue
    for (int i = 0; i < 5; i++) begin
      pi_write(3'd2, 16'(256 + i));
      w = {2'b00, 3'(i), 1'b1, 2'b10, 8'(32 + i)};
      pi_write(3'd3, w);
    end
    read_reg(3'd4, v);
    check("overflow status", v, 16'h001E);
    check_model("overflow");
    pi_write(3'd4, 16'h4000);
    read_reg(3'd4, v);
    check("overflow cleared status", v, 16'h000E);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d req_valid", i), bus_if.REQ_VALID, 1);
      check($sformatf("drain%0d req_address", i), bus_if.REQ_ADDRESS, {8'(32 + i), 16'(256 + i)});
      check($sformatf("drain%0d req_fc", i), bus_if.REQ_FC, 3'(i));
      handshake();
      respond($urandom, 1'b1);
      check_model($sformatf("drain%0d", i));
    end
    check("drained busy", PI_BUSY, 0);

    // Push coinciding with handshake while full
    for (int i = 0; i < 4; i++) begin
      pi_write(3'd2, 16'(512 + i));
      pi_write(3'd3, {8'h00, 8'(48 + i)});
    end
    pi_write(3'd2, 16'd516);
    @(negedge SYSCLK);
    PI_A = 3'd3;
    PI_DATA_IN = 16'h0034;
    PI_WR = 1'b0;
    repeat (3) @(negedge SYSCLK);
    bus_if.REQ_READY = 1'b1;
    @(negedge SYSCLK);
    bus_if.REQ_READY = 1'b0;
    repeat (2) @(negedge SYSCLK);
    PI_WR = 1'b1;
    repeat (4) @(negedge SYSCLK);
    mq.delete(0);
    m_inflight = 1;
    model_write(3'd3, 16'h0034);
    read_reg(3'd4, v);
    check("pushpop full/ovf/inflight", v & 16'h0019, 16'h0009);
    check_model("pushpop");
    respond(32'h0BADF00D, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pushpop order%0d", i), bus_if.REQ_ADDRESS[23:16], 8'(49 + i));
      handshake();
      respond($urandom, 1'b1);
      check_model($sformatf("pushpop drain%0d", i));
    end

    // Reset mid-flight with a response during reset
    for (int i = 0; i < 3; i++) pi_write(3'd3, 16'(64 + i));
    handshake();
    check_model("pre-reset");
    @(negedge SYSCLK);
    RESET = 1'b1;
    bus_if.RSP_VALID = 1'b1;
    bus_if.RSP_DATA = 32'h12345678;
    bus_if.RSP_TERM_OK = 1'b1;
    @(negedge SYSCLK);
    RESET = 1'b0;
    bus_if.RSP_VALID = 1'b0;
    model_reset();
    read_reg(3'd4, v);
    check("midreset status", v, 16'h0000);
    check("midreset busy", PI_BUSY, 0);
    respond(32'hCAFEF00D, 1'b1);
    read_reg(3'd0, v);
    check("midreset late rsp data_lo", v, 16'h0000);
    read_reg(3'd1, v);
    check("midreset late rsp data_hi", v, 16'h0000);
    check_model("midreset");

    // Randomised operations against the model
    for (int n = 0; n < 80; n++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 2)      pi_write(3'($urandom_range(0, 2)), 16'($urandom));
      else if (act <= 4) pi_write(3'd3, 16'($urandom));
      else if (act == 5) pi_write(3'd4, 16'($urandom));
      else if (act <= 7) handshake();
      else               respond($urandom, 1'($urandom));
      check_model($sformatf("rand%0d op%0d", n, act));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
